// File: rtl/ct_piu_snb_rresp_arb.sv
// Read-response return stage: arbitrates SNB0/SNB1 R-beats into a small FIFO toward
// the core, and acks each burst to its SNB once the burst's last beat is popped.
module ct_piu_snb_rresp_arb #(
  parameter int unsigned UPKB_WIDTH = 535,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned PTR_W      = 1
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  snb0_piu_rvalid,
  input  logic [UPKB_WIDTH-1:0] snb0_piux_rbus,
  input  logic                  snb1_piu_rvalid,
  input  logic [UPKB_WIDTH-1:0] snb1_piux_rbus,
  output logic                  piu_snb0_r_grant,
  output logic                  piu_snb1_r_grant,
  output logic                  piu_core_rvalid,
  output logic [UPKB_WIDTH-1:0] piu_core_rbus,
  input  logic                  core_piu_rready,
  output logic                  piu_snb0_rack,
  output logic                  piu_snb1_rack,
  output logic [4:0]            piu_snbx_rack_sid,
  output logic                  piu_xx_no_op
);

  localparam int unsigned ENT_W     = UPKB_WIDTH + 1;
  localparam int unsigned SRC_BIT   = UPKB_WIDTH;
  localparam int unsigned LAST_BIT  = 5;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_LOCK0  = 2'd1;
  localparam logic [1:0]  ST_LOCK1  = 2'd2;
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

  logic [1:0]                       r_state;
  logic [1:0]                       w_state_nxt;
  logic                             r_rr_ptr;
  logic                             w_rr_ptr_nxt;
  logic [FIFO_DEPTH-1:0][ENT_W-1:0] r_mem;
  logic [PTR_W-1:0]                 r_wr_ptr;
  logic [PTR_W-1:0]                 r_rd_ptr;
  logic [PTR_W:0]                   r_count;
  logic                             r_rack0;
  logic                             r_rack1;
  logic [4:0]                       r_rack_sid;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_room;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_pop_last;
  logic [ENT_W-1:0] w_head;
  logic [ENT_W-1:0] w_push_ent;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == DEPTH_CNT);
  assign w_head     = r_mem[r_rd_ptr];
  assign w_pop      = !w_empty && core_piu_rready;
  // A full FIFO can still take a beat when the head leaves in the same cycle
  assign w_room     = !w_full || w_pop;
  assign w_push     = w_gnt0 || w_gnt1;
  assign w_push_ent = w_gnt1 ? {1'b1, snb1_piux_rbus} : {1'b0, snb0_piux_rbus};
  assign w_pop_last = w_pop && w_head[LAST_BIT];

  // Arbitration state register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state  <= ST_IDLE;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Grant selection and next-state; a lock holds the path until its burst ends
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    case (r_state)
      ST_LOCK0: w_gnt0 = snb0_piu_rvalid && w_room;
      ST_LOCK1: w_gnt1 = snb1_piu_rvalid && w_room;
      default: begin
        if (w_room) begin
          if (snb0_piu_rvalid && snb1_piu_rvalid) begin
            w_gnt0 = !r_rr_ptr;
            w_gnt1 = r_rr_ptr;
          end else begin
            w_gnt0 = snb0_piu_rvalid;
            w_gnt1 = snb1_piu_rvalid;
          end
        end
      end
    endcase
    if (w_gnt0) begin
      if (snb0_piux_rbus[LAST_BIT]) begin
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = 1'b1;
      end else begin
        w_state_nxt  = ST_LOCK0;
      end
    end else if (w_gnt1) begin
      if (snb1_piux_rbus[LAST_BIT]) begin
        w_state_nxt  = ST_IDLE;
        w_rr_ptr_nxt = 1'b0;
      end else begin
        w_state_nxt  = ST_LOCK1;
      end
    end
  end

  // Return FIFO: entry = {source id, beat}
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_ent;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  // Burst-complete ack, one cycle after the last beat is popped
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rack0    <= 1'b0;
      r_rack1    <= 1'b0;
      r_rack_sid <= 5'd0;
    end else begin
      r_rack0    <= w_pop_last && !w_head[SRC_BIT];
      r_rack1    <= w_pop_last && w_head[SRC_BIT];
      r_rack_sid <= w_pop_last ? w_head[4:0] : 5'd0;
    end
  end

  assign piu_snb0_r_grant  = w_gnt0;
  assign piu_snb1_r_grant  = w_gnt1;
  assign piu_core_rvalid   = !w_empty;
  assign piu_core_rbus     = w_head[UPKB_WIDTH-1:0];
  assign piu_snb0_rack     = r_rack0;
  assign piu_snb1_rack     = r_rack1;
  assign piu_snbx_rack_sid = r_rack_sid;
  assign piu_xx_no_op      = w_empty && !r_rack0 && !r_rack1
                             && !snb0_piu_rvalid && !snb1_piu_rvalid;

endmodule

// File: tb/tb_ct_piu_snb_rresp_arb.sv
// Bench for ct_piu_snb_rresp_arb: SNB burst drivers plus a queue-based reference
// model of arbitration, FIFO contents and rack timing, checked by a separate monitor.
module tb_ct_piu_snb_rresp_arb;

  localparam int unsigned W     = 535;
  localparam int          DEPTH = 2;

  logic         clk;
  logic         rst_n;
  logic         rv0, rv1, rready;
  logic [W-1:0] bus0, bus1;
  logic         grant0, grant1, core_rvalid, rack0, rack1, no_op;
  logic [W-1:0] core_rbus;
  logic [4:0]   rack_sid;

  ct_piu_snb_rresp_arb dut (
    .forever_cpuclk    (clk),
    .cpurst_b          (rst_n),
    .snb0_piu_rvalid   (rv0),
    .snb0_piux_rbus    (bus0),
    .snb1_piu_rvalid   (rv1),
    .snb1_piux_rbus    (bus1),
    .piu_snb0_r_grant  (grant0),
    .piu_snb1_r_grant  (grant1),
    .piu_core_rvalid   (core_rvalid),
    .piu_core_rbus     (core_rbus),
    .core_piu_rready   (rready),
    .piu_snb0_rack     (rack0),
    .piu_snb1_rack     (rack1),
    .piu_snbx_rack_sid (rack_sid),
    .piu_xx_no_op      (no_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  typedef struct {
    logic [W-1:0] bus;
    int           src;
  } ent_t;

  ent_t     q[$];
  int       lock   = -1;
  int       rr     = 0;
  bit       rk_v   = 0;
  int       rk_src = 0;
  logic [4:0] rk_sid = '0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        q.delete();
        lock = -1;
        rr   = 0;
        rk_v = 0;
        chk("rst_grant0", W'(grant0), W'(0));
        chk("rst_grant1", W'(grant1), W'(0));
        chk("rst_rvalid", W'(core_rvalid), W'(0));
        chk("rst_rbus",   core_rbus, W'(0));
        chk("rst_rack0",  W'(rack0), W'(0));
        chk("rst_rack1",  W'(rack1), W'(0));
        chk("rst_sid",    W'(rack_sid), W'(0));
        chk("rst_no_op",  W'(no_op), W'(1));
      end else begin
        bit pop, room, g0, g1, nrk_v;
        ent_t e;
        pop  = (q.size() > 0) && rready;
        room = (q.size() < DEPTH) || pop;
        g0 = 0;
        g1 = 0;
        if (room) begin
          if (lock == 0)      g0 = rv0;
          else if (lock == 1) g1 = rv1;
          else if (rv0 && rv1) begin
            g0 = (rr == 0);
            g1 = (rr == 1);
          end else begin
            g0 = rv0;
            g1 = rv1;
          end
        end
        chk("grant0", W'(grant0), W'(g0));
        chk("grant1", W'(grant1), W'(g1));
        chk("core_rvalid", W'(core_rvalid), W'(q.size() > 0));
        if (q.size() > 0) chk("core_rbus", core_rbus, q[0].bus);
        chk("rack0", W'(rack0), W'(rk_v && rk_src == 0));
        chk("rack1", W'(rack1), W'(rk_v && rk_src == 1));
        if (rk_v) chk("rack_sid", W'(rack_sid), W'(rk_sid));
        chk("no_op", W'(no_op), W'((q.size() == 0) && !rk_v && !rv0 && !rv1));
        // advance the model across the coming clock edge
        nrk_v = 0;
        if (pop) begin
          e = q.pop_front();
          if (e.bus[5]) begin
            nrk_v  = 1;
            rk_src = e.src;
            rk_sid = e.bus[4:0];
          end
        end
        rk_v = nrk_v;
        if (g0 || g1) begin
          e.bus = g0 ? bus0 : bus1;
          e.src = g0 ? 0 : 1;
          q.push_back(e);
          if (e.bus[5]) begin
            lock = -1;
            rr   = 1 - e.src;
          end else begin
            lock = e.src;
          end
        end
      end
    end
  end

  // ---------------- SNB burst drivers ----------------
  bit           act[2];
  bit           gseen[2];
  int           left[2];
  logic [4:0]   sidv[2];
  logic [W-1:0] cur[2];

  function automatic logic [W-1:0] mk_beat(input bit last, input logic [4:0] sid);
    logic [543:0] t;
    logic [W-1:0] b;
    for (int i = 0; i < 17; i++) t[i*32 +: 32] = $urandom;
    b      = t[W-1:0];
    b[5]   = last;
    b[4:0] = sid;
    return b;
  endfunction

  task automatic start_burst(input int s, input int len, input logic [4:0] sid);
    if (!act[s]) begin
      act[s]  = 1;
      left[s] = len;
      sidv[s] = sid;
      cur[s]  = mk_beat(len == 1, sid);
    end
  endtask

  task automatic step(input int p0, input int p1, input int maxlen, input int prdy);
    @(negedge clk);
    if ($urandom_range(99) < p0) start_burst(0, int'($urandom_range(maxlen, 1)), 5'($urandom));
    if ($urandom_range(99) < p1) start_burst(1, int'($urandom_range(maxlen, 1)), 5'($urandom));
    rv0    = act[0];
    bus0   = cur[0];
    rv1    = act[1];
    bus1   = cur[1];
    rready = ($urandom_range(99) < prdy);
    #4;
    gseen[0] = grant0;
    gseen[1] = grant1;
    for (int s = 0; s < 2; s++) begin
      if (act[s] && gseen[s]) begin
        left[s]--;
        if (left[s] == 0) act[s] = 0;
        else cur[s] = mk_beat(left[s] == 1, sidv[s]);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 0;
    rv0    = 0;
    rv1    = 0;
    rready = 0;
    for (int s = 0; s < 2; s++) begin
      act[s]   = 0;
      gseen[s] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n  = 0;
    rv0    = 0;
    rv1    = 0;
    rready = 0;
    bus0   = '0;
    bus1   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) step(0, 0, 1, 100);

    // single beat, sid 03, ready high
    start_burst(0, 1, 5'h03);
    repeat (4) step(0, 0, 1, 100);

    // contention between single-beat bursts
    do_reset();
    for (int i = 0; i < 6; i++) begin
      start_burst(0, 1, 5'($urandom));
      start_burst(1, 1, 5'($urandom));
      step(0, 0, 1, 100);
    end
    repeat (4) step(0, 0, 1, 100);

    // SNB1 4-beat lock while SNB0 keeps requesting
    start_burst(1, 4, 5'h11);
    step(0, 0, 1, 100);
    start_burst(0, 1, 5'h02);
    repeat (8) step(0, 0, 1, 100);

    // backpressure: 3 beats offered into a 2-entry FIFO
    do_reset();
    start_burst(0, 3, 5'h07);
    repeat (4) step(0, 0, 1, 0);
    repeat (6) step(0, 0, 1, 100);

    // reset while locked on SNB0 with a full FIFO
    start_burst(0, 4, 5'h1a);
    repeat (3) step(0, 0, 1, 0);
    do_reset();
    start_burst(0, 1, 5'h04);
    start_burst(1, 1, 5'h05);
    repeat (6) step(0, 0, 1, 100);

    // randomized traffic with random backpressure
    for (int i = 0; i < 1500; i++) step(35, 35, 4, 70);
    for (int i = 0; i < 1500; i++) step(90, 90, 3, 100);
    for (int i = 0; i < 500; i++)  step(20, 60, 5, 30);

    // drain to idle
    repeat (20) step(0, 0, 1, 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
